// File: rtl/auth_pkg.sv
// auth_pkg: shared state and outcome encodings for the authentication port arbiter
package auth_pkg;
  typedef enum logic [2:0] {IDLE, GRANT, ACTIVE, REPORT, RELEASE} state_t;
  typedef enum logic [1:0] {
    RES_NONE    = 2'b00,
    RES_UNLOCK  = 2'b01,
    RES_LOCKOUT = 2'b10,
    RES_EXPIRED = 2'b11
  } result_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first eligible port above ptr (wrapping)
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] win_idx,
  output logic          valid
);
  logic [PW-1:0] idx;
  always_comb begin
    win     = '0;
    win_idx = '0;
    idx     = '0;
    for (int i = N; i >= 1; i--) begin
      idx = PW'((int'(ptr) + i) % N);
      if (eligible[idx]) begin
        win     = N'(1) << idx;
        win_idx = idx;
      end
    end
    valid = |eligible;
  end
endmodule

// File: rtl/auth_port_arbiter.sv
// auth_port_arbiter: round-robin sharing of one OTP engine among keypad ports, with per-port lockout
module auth_port_arbiter
  import auth_pkg::*;
#(
  parameter int N_PORTS     = 4,
  parameter int LOCK_CYCLES = 500_000_000,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_PORTS-1:0]     req,
  input  logic [4*N_PORTS-1:0]   port_digit,
  input  logic [N_PORTS-1:0]     port_latch,
  input  logic                   unlock,
  input  logic                   reset_sys,
  input  logic                   expired,
  output logic [N_PORTS-1:0]     grant,
  output logic                   gen_latch,
  output logic [3:0]             otp_digit,
  output logic                   otp_latch,
  output logic [N_PORTS-1:0]     done,
  output logic [1:0]             result,
  output logic [N_PORTS-1:0]     locked_out,
  output logic                   busy
);
  localparam int PW = $clog2(N_PORTS);
  state_t state, state_d;
  result_t res_q, res_d;
  logic [PW-1:0] ptr, win_idx;
  logic [N_PORTS-1:0] win;
  logic win_v, gcnt, cause;
  logic [1:0] rcnt;
  logic [2:0] fq, fqq, rise;
  rr_pick #(.N(N_PORTS), .PW(PW)) u_pick (
    .eligible(req & ~locked_out),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .valid   (win_v)
  );
  // flags are registered twice so only edges arriving after sampling count
  assign rise      = fq & ~fqq;
  assign cause     = res_q == RES_UNLOCK ? unlock : res_q == RES_LOCKOUT ? reset_sys : expired;
  assign gen_latch = state == GRANT;
  assign busy      = state != IDLE;
  assign done      = state == REPORT ? grant : '0;
  assign result    = res_q;
  always_comb begin
    state_d = state;
    res_d   = res_q;
    case (state)
      IDLE:    if (win_v) state_d = GRANT;
      GRANT:   if (gcnt) state_d = ACTIVE;
      ACTIVE:  if (|rise) begin
        state_d = REPORT;
        res_d   = rise[0] ? RES_UNLOCK : rise[1] ? RES_LOCKOUT : RES_EXPIRED;
      end
      REPORT:  state_d = RELEASE;
      RELEASE: if (!cause && rcnt == 2'd2) begin
        state_d = IDLE;
        res_d   = RES_NONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      res_q     <= RES_NONE;
      ptr       <= '0;
      grant     <= '0;
      gcnt      <= 1'b0;
      rcnt      <= 2'd0;
      fq        <= 3'b0;
      fqq       <= 3'b0;
      otp_digit <= 4'd0;
      otp_latch <= 1'b0;
    end else begin
      state     <= state_d;
      res_q     <= res_d;
      fq        <= {expired, reset_sys, unlock};
      fqq       <= fq;
      gcnt      <= state == GRANT && !gcnt;
      rcnt      <= (state != RELEASE || cause) ? 2'd0 : rcnt + 2'd1;
      otp_latch <= state == ACTIVE && |(port_latch & grant);
      otp_digit <= state == ACTIVE ? port_digit[{ptr, 2'b00} +: 4] : 4'd0;
      if (state == IDLE && win_v) begin
        grant <= win;
        ptr   <= win_idx;
      end else if (state == RELEASE && state_d == IDLE) begin
        grant <= '0;
      end
    end
  end
  for (genvar k = 0; k < N_PORTS; k++) begin : g_lock
    logic [CNT_W-1:0] cnt, nxt;
    logic lo;
    assign nxt = (state == REPORT && res_q == RES_LOCKOUT && ptr == PW'(k)) ? CNT_W'(LOCK_CYCLES)
               : cnt != '0 ? cnt - 1'b1 : '0;
    assign locked_out[k] = lo;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt <= '0;
        lo  <= 1'b0;
      end else begin
        cnt <= nxt;
        lo  <= nxt != '0;
      end
    end
  end
endmodule

// File: tb/tb_auth_port_arbiter.sv
// tb_auth_port_arbiter: randomized self-checking bench against a round-robin session model
module tb_auth_port_arbiter;
  localparam int N  = 4;
  localparam int LC = 20;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] req = '0, port_latch = '0;
  logic [15:0] port_digit = '0;
  logic unlock = 1'b0, reset_sys = 1'b0, expired = 1'b0;
  logic [3:0] grant, done, locked_out, otp_digit;
  logic gen_latch, otp_latch, busy;
  logic [1:0] result;
  int n_tests = 0, n_fail = 0, mptr = 0;

  auth_port_arbiter #(.N_PORTS(N), .LOCK_CYCLES(LC), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .port_digit(port_digit), .port_latch(port_latch),
    .unlock(unlock), .reset_sys(reset_sys), .expired(expired), .grant(grant),
    .gen_latch(gen_latch), .otp_digit(otp_digit), .otp_latch(otp_latch), .done(done),
    .result(result), .locked_out(locked_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // model: first requesting port strictly after p, wrapping
  function automatic int pick(input logic [3:0] el, input int p);
    for (int i = 1; i <= N; i++) if (el[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic reset_dut;
    reset = 1'b0; req = '0; port_latch = '0; port_digit = '0;
    unlock = 1'b0; reset_sys = 1'b0; expired = 1'b0;
    repeat (2) tick;
    reset = 1'b1;
    mptr = 0;
  endtask

  task automatic wait_idle;
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 60) begin
      tick;
      k++;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, k);
    end
  endtask

  task automatic run_session(input logic [3:0] rq, input logic [2:0] fl, input int ndig,
                             input logic [15:0] digs, input bit rnd, input bit drop,
                             output logic [3:0] g_seen);
    int own;
    logic [3:0] oh, d;
    logic [1:0] er;
    bit lk;
    own = pick(rq, mptr);
    oh  = 4'(1) << own;
    er  = fl[0] ? 2'b01 : fl[1] ? 2'b10 : 2'b11;
    lk  = er == 2'b10;
    req = rq;
    tick;
    g_seen = grant;
    n_tests++;
    if (grant !== oh || gen_latch !== 1'b1) begin
      n_fail++;
      $display("FAIL grant: grant=%b gen_latch=%b, required %b/1", grant, gen_latch, oh);
    end
    tick;
    n_tests++;
    if (gen_latch !== 1'b1 || grant !== oh) begin
      n_fail++;
      $display("FAIL gen_latch2: gen_latch=%b grant=%b, required 1/%b", gen_latch, grant, oh);
    end
    tick;
    n_tests++;
    if (gen_latch !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL active_entry: gen_latch=%b busy=%b, required 0/1", gen_latch, busy);
    end
    mptr = own;
    if (drop) req = '0;
    for (int i = 0; i < ndig; i++) begin
      d = rnd ? 4'($urandom_range(0, 15)) : digs[4*i +: 4];
      port_digit = 16'($urandom);
      port_digit[4*own +: 4] = d;
      port_latch = oh | (rnd ? 4'($urandom) : 4'b0);
      tick;
      port_latch = '0;
      n_tests++;
      if (otp_latch !== 1'b1 || otp_digit !== d) begin
        n_fail++;
        $display("FAIL digit: otp_latch=%b otp_digit=%h, required 1/%h", otp_latch, otp_digit, d);
      end
      tick;
      n_tests++;
      if (otp_latch !== 1'b0) begin
        n_fail++;
        $display("FAIL latch_pulse: otp_latch=%b, required 0", otp_latch);
      end
    end
    {expired, reset_sys, unlock} = fl;
    tick;
    n_tests++;
    if (done !== 4'b0) begin
      n_fail++;
      $display("FAIL done_early: done=%b, required 0000", done);
    end
    tick;
    n_tests++;
    if (done !== oh || result !== er) begin
      n_fail++;
      $display("FAIL outcome: done=%b result=%b, required %b/%b", done, result, oh, er);
    end
    tick;
    n_tests++;
    if (done !== 4'b0 || locked_out !== (lk ? oh : 4'b0)) begin
      n_fail++;
      $display("FAIL post_report: done=%b locked_out=%b, required 0000/%b", done, locked_out, lk ? oh : 4'b0);
    end
    {expired, reset_sys, unlock} = 3'b0;
    wait_idle;
    n_tests++;
    if (grant !== 4'b0 || result !== 2'b00) begin
      n_fail++;
      $display("FAIL release: grant=%b result=%b, required 0000/00", grant, result);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick;
    n_tests++;
    if (grant !== 4'b0 || done !== 4'b0 || locked_out !== 4'b0 || result !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_vec: grant=%b done=%b locked_out=%b result=%b, required all 0", grant, done, locked_out, result);
    end
    n_tests++;
    if (gen_latch !== 1'b0 || otp_latch !== 1'b0 || busy !== 1'b0 || otp_digit !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_ctl: gen=%b otp_latch=%b busy=%b digit=%h, required all 0", gen_latch, otp_latch, busy, otp_digit);
    end
    reset_dut;
  endtask

  task automatic test_single;
    logic [3:0] g;
    reset_dut;
    run_session(4'b0010, 3'b001, 4, 16'h4321, 1'b0, 1'b0, g);
  endtask

  task automatic test_round_robin;
    logic [3:0] g;
    logic [3:0] exp_g [4];
    exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset_dut;
    for (int i = 0; i < 4; i++) begin
      run_session(4'hF, 3'b001, 1, 16'h0005, 1'b0, 1'b0, g);
      n_tests++;
      if (g !== exp_g[i]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: grant=%b, required %b", i, g, exp_g[i]);
      end
    end
  endtask

  task automatic test_isolation;
    reset_dut;
    req = 4'b0100;
    repeat (3) tick;
    n_tests++;
    if (grant !== 4'b0100 || gen_latch !== 1'b0) begin
      n_fail++;
      $display("FAIL iso_owner: grant=%b gen_latch=%b, required 0100/0", grant, gen_latch);
    end
    port_digit = 16'h0009;
    port_latch = 4'b0001;
    tick;
    port_latch = '0;
    n_tests++;
    if (otp_latch !== 1'b0) begin
      n_fail++;
      $display("FAIL iso_strobe: otp_latch=%b, required 0", otp_latch);
    end
    unlock = 1'b1;
    tick;
    tick;
    n_tests++;
    if (done !== 4'b0100 || result !== 2'b01) begin
      n_fail++;
      $display("FAIL iso_done: done=%b result=%b, required 0100/01", done, result);
    end
    unlock = 1'b0;
    wait_idle;
  endtask

  task automatic test_lockout;
    int lo_cnt, lo_first, lo_fall, g_rise;
    bit gz;
    lo_cnt = 0; lo_first = -1; lo_fall = -1; g_rise = -1; gz = 1'b0;
    reset_dut;
    req = 4'b1000;
    repeat (3) tick;
    reset_sys = 1'b1;
    tick;
    tick;
    n_tests++;
    if (done !== 4'b1000 || result !== 2'b10) begin
      n_fail++;
      $display("FAIL lock_outcome: done=%b result=%b, required 1000/10", done, result);
    end
    reset_sys = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      tick;
      if (locked_out[3]) begin
        lo_cnt++;
        if (lo_first < 0) lo_first = i;
      end else if (lo_first >= 0 && lo_fall < 0) lo_fall = i;
      if (grant == 4'b0) gz = 1'b1;
      else if (gz && g_rise < 0) g_rise = i;
    end
    n_tests++;
    if (lo_first !== 1 || lo_cnt !== LC) begin
      n_fail++;
      $display("FAIL lock_window: first=%0d cycles=%0d, required 1/%0d", lo_first, lo_cnt, LC);
    end
    n_tests++;
    if (lo_fall !== LC + 1 || g_rise !== lo_fall + 1) begin
      n_fail++;
      $display("FAIL lock_regrant: fall=%0d grant_at=%0d, required %0d/%0d", lo_fall, g_rise, LC + 1, LC + 2);
    end
    n_tests++;
    if (grant !== 4'b1000) begin
      n_fail++;
      $display("FAIL lock_owner: grant=%b, required 1000", grant);
    end
  endtask

  task automatic test_simultaneous;
    logic [3:0] g;
    reset_dut;
    run_session(4'b0001, 3'b101, 2, 16'h0, 1'b1, 1'b0, g);
    run_session(4'b0001, 3'b111, 1, 16'h0, 1'b1, 1'b0, g);
    run_session(4'b0001, 3'b110, 1, 16'h0, 1'b1, 1'b0, g);
  endtask

  task automatic test_reset_mid;
    reset_dut;
    req = 4'b0010;
    repeat (3) tick;
    port_digit = 16'h0070;
    port_latch = 4'b0010;
    tick;
    port_latch = '0;
    n_tests++;
    if (otp_digit !== 4'h7 || otp_latch !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_digit: otp_digit=%h otp_latch=%b, required 7/1", otp_digit, otp_latch);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (grant !== 4'b0 || busy !== 1'b0 || otp_latch !== 1'b0 || otp_digit !== 4'd0 || done !== 4'b0 || result !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset: grant=%b busy=%b otp_latch=%b digit=%h done=%b result=%b, required all 0",
               grant, busy, otp_latch, otp_digit, done, result);
    end
    tick;
    reset = 1'b1;
    req = 4'b0001;
    tick;
    n_tests++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_regrant: grant=%b, required 0001", grant);
    end
  endtask

  task automatic test_random;
    logic [3:0] g, rq;
    logic [2:0] fl;
    reset_dut;
    for (int s = 0; s < 16; s++) begin
      rq = 4'($urandom_range(1, 15));
      fl = 3'($urandom_range(1, 7));
      run_session(rq, fl, $urandom_range(0, 4), 16'h0, 1'b1, 1'($urandom_range(0, 1)), g);
      if (!fl[0] && fl[1]) begin
        req = '0;
        repeat (25) tick;
        n_tests++;
        if (locked_out !== 4'b0) begin
          n_fail++;
          $display("FAIL lock_expire: locked_out=%b, required 0000", locked_out);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_isolation;
    test_lockout;
    test_simultaneous;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/auth_port_arbiter.md
# auth_port_arbiter

Shares the single OTP authentication engine (`fsm`) among `N_PORTS` keypad requesters. Grants one port at a time by round-robin and triggers OTP generation for that session. Forwards only the granted port's digit strobes to the engine, then reports the session outcome to that port. Ports that trip the engine's multi-failure reset are locked out for a programmable time. Sits between the keypad front-ends and `fsm`: it drives `fsm.lfsr_latch`, `fsm.user_digit` and `fsm.user_latch`, and consumes `unlock`, `reset_sys` and `expired`.

## Interface
- `N_PORTS`, 4: number of requesters (2..8).
- `LOCK_CYCLES`, 500_000_000: lockout duration per offending port, in clocks.
- `CNT_W`, 32: lockout counter width; must hold `LOCK_CYCLES`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-low.
- `req` in `N_PORTS`: level request, one bit per port.
- `port_digit` in `4*N_PORTS`: digit of port k in bits [4k+3:4k].
- `port_latch` in `N_PORTS`: one-cycle digit strobe per port.
- `unlock`, `reset_sys`, `expired` in 1 each: status flags from `fsm`.
- `grant` out `N_PORTS`: one-hot current owner; all zero when no owner.
- `gen_latch` out 1: to `fsm.lfsr_latch`.
- `otp_digit` out 4: to `fsm.user_digit`.
- `otp_latch` out 1: to `fsm.user_latch`.
- `done` out `N_PORTS`: one-cycle outcome pulse to the owner.
- `result` out 2: outcome code, valid while `done` is non-zero. 01 = UNLOCK, 10 = LOCKOUT, 11 = EXPIRED.
- `locked_out` out `N_PORTS`: port currently barred.
- `busy` out 1: session in progress (state ≠ IDLE).

## Operation
- Reset values: `grant`, `done`, `locked_out` = 0; `result` = 00; `gen_latch`, `otp_latch`, `busy` = 0; `otp_digit` = 0. RR pointer = 0; lockout counters = 0; state = IDLE.
- States: IDLE → GRANT → ACTIVE → REPORT → RELEASE → IDLE.
- **IDLE**
  - Eligible = `req & ~locked_out`.
  - Pick the first eligible port searching upward from `ptr+1`, modulo `N_PORTS`.
  - Register `grant`, set `ptr` to the winner, go to GRANT.
  - No eligible port: stay in IDLE.
- **GRANT**
  - Lasts 2 cycles with `gen_latch` = 1 on both, then goes to ACTIVE.
  - The engine ignores `lfsr_latch` outside its generate state, so the second pulse is harmless.
- **ACTIVE**
  - `otp_digit` and `otp_latch` are registered copies of the owner's `port_digit` and `port_latch`. Non-owner strobes are dropped.
  - Rising edge of `unlock` → result 01. Rising edge of `reset_sys` → result 10. Rising edge of `expired` → result 11. Priority when simultaneous: `unlock` > `reset_sys` > `expired`.
  - On any of these, go to REPORT.
  - Wrong-digit retries are internal to the engine and not visible here.
- **REPORT**
  - One cycle: `done[owner]` = 1 and `result` is driven.
  - For result 10, load the owner's lockout counter with `LOCK_CYCLES`.
  - Then go to RELEASE.
- **RELEASE**
  - Wait until the flag that caused the outcome is low, plus 2 more cycles, so the engine is back in its generate state.
  - Then clear `grant`, return `result` to 00, go to IDLE.
- **Lockout**
  - Each counter decrements to 0 and saturates there.
  - `locked_out[k]` = (counter ≠ 0), registered.
  - Counters run in every state, including for the port that currently owns a session.
- **Requests during a session**
  - The owner dropping `req` mid-session does not abort it. The engine has no abort input, so the session always runs to an outcome.
  - Other ports' requests wait; no queueing beyond level sensing.
- Outcome flags already high when ACTIVE is entered are not counted; only rising edges count. This requires a registered previous value of each flag.
- Asynchronous reset mid-session returns to the reset values above immediately. The engine shares the same reset.

## Timing
- Request to `grant`: 1 cycle from the IDLE sample edge.
- `gen_latch` high on GRANT cycles 1–2; ACTIVE begins on the 3rd cycle after `grant` rises.
- Digit forwarding latency: `port_latch` at cycle t → `otp_latch` at t+1, with matching `otp_digit`.
- Flag rise at cycle t → `done` pulse at t+2: edge detect, then REPORT.
- Port is eligible again the cycle after `locked_out` falls.
- Minimum back-to-back session turnaround: RELEASE exit → IDLE → new `grant` 1 cycle later.

## Structure
- Shared package `auth_pkg`:
  - state encoding: IDLE, GRANT, ACTIVE, REPORT, RELEASE;
  - result codes: RES_NONE, RES_UNLOCK, RES_LOCKOUT, RES_EXPIRED.
- Sub-module `rr_pick`: combinational round-robin selector taking (eligible, `ptr`) and producing a one-hot winner plus a valid bit.
- Lockout counters are a generate loop inside the top module.

## Test plan
- **Single session:** `N_PORTS`=4, `LOCK_CYCLES`=20. `req`=0010 → `grant`=0010 one cycle later, then `gen_latch` high for 2 cycles. Port 1 strobes digits 1,2,3,4 → `otp_latch` ×4 with `otp_digit` 1..4. `unlock` rises → `done`=0010 with `result`=01.
- **Round-robin:** `req`=1111 held, every session ends in `unlock` → grants in order 0010, 0100, 1000, 0001.
- **Strobe isolation:** while port 2 owns the session, port 0 strobes digit 9 → `otp_latch` stays 0.
- **Lockout:** `reset_sys` rises while port 3 owns the session → `result`=10 and `locked_out[3]` high for 20 cycles. Port 3 is not granted during that window even with `req`=1000. Port 3 is granted after the window.
- **Simultaneous flags:** `unlock` and `expired` rise on the same cycle → `result`=01.
- **Reset mid-session:** assert `reset` during ACTIVE → all outputs 0; after release, `req`=0001 → `grant`=0001.
